// File: rtl/jesd_tx_burst_gen_if.sv
// rtl/jesd_tx_burst_gen_if.sv - TX data stream bundle between burst generator and JESD TX core
// Signals:
//   tx_tdata  : TX word presented to the JESD TX core
//   tx_tready : JESD TX core ready; a word is consumed on each clk edge with tx_tready=1
// Modports: master = burst generator side, slave = JESD TX core side.
interface jesd_tx_burst_gen_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tx_tdata;
  logic              tx_tready;

  modport master (output tx_tdata, input tx_tready);
  modport slave  (input tx_tdata, output tx_tready);
endinterface

// File: rtl/jesd_tx_burst_gen.sv
// rtl/jesd_tx_burst_gen.sv - triggered burst generator of a 16-bit sample ramp for JESD TX loopback
// Ports:
//   clk       : JESD core clock (single domain)
//   resetn    : synchronous active-low reset
//   trig_in   : asynchronous switch level; a rising edge starts one burst
//   tx        : TX stream (master) - tx_tdata out {sample n+1, sample n}, tx_tready in
//   busy      : high from trigger acceptance until the burst completes
//   done      : one-cycle pulse after the last word is consumed
//   burst_cnt : completed bursts, wraps at 16'hFFFF
module jesd_tx_burst_gen #(
  parameter int          DATA_W      = 32,
  parameter int          BURST_LEN   = 256,
  parameter logic [15:0] START_VAL   = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                trig_in,
  jesd_tx_burst_gen_if.master tx,
  output logic                busy,
  output logic                done,
  output logic [15:0]         burst_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, DONE} state_t;

  state_t                   state, next_state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     delay_q;
  logic                     trig_edge;
  logic [15:0]              sample_q, sample_d;
  logic [15:0]              word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]        tdata_q, tdata_d;
  logic                     busy_d, done_d;

  // Metastability chain followed by a delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], trig_in};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign trig_edge = sync_q[SYNC_STAGES-1] & ~delay_q;

  // State register, plus the registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      sample_q   <= 16'h0000;
      word_cnt_q <= 16'h0000;
      tdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      burst_cnt  <= 16'h0000;
    end else begin
      state      <= next_state;
      sample_q   <= sample_d;
      word_cnt_q <= word_cnt_d;
      tdata_q    <= tdata_d;
      busy       <= busy_d;
      done       <= done_d;
      if (done_d) begin
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (trig_edge) next_state = WAIT_RDY;
      WAIT_RDY: if (tx.tx_tready) next_state = SEND;
      SEND:     if (tx.tx_tready && word_cnt_q == LAST_IDX) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic. Outputs are computed from the next state so that the
  // registered versions line up with the state they belong to; tx_tready
  // therefore only reaches tx_tdata through a flop.
  always_comb begin
    sample_d   = sample_q;
    word_cnt_d = word_cnt_q;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          sample_d   = START_VAL;
          word_cnt_d = 16'h0000;
        end
      end
      SEND: begin
        if (tx.tx_tready) begin
          sample_d   = sample_q + 16'd2;
          word_cnt_d = word_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    tdata_d = '0;
    if (next_state == SEND) begin
      tdata_d = DATA_W'({sample_d + 16'd1, sample_d});
    end
    busy_d = (next_state == WAIT_RDY) || (next_state == SEND);
    done_d = (next_state == DONE);
  end

  assign tx.tx_tdata = tdata_q;

endmodule

// File: tb/tb_jesd_tx_burst_gen.sv
// tb/tb_jesd_tx_burst_gen.sv - self-checking bench for jesd_tx_burst_gen
module tb_jesd_tx_burst_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut_a: BURST_LEN=4, START_VAL=0
  logic        rst_a, trig_a, busy_a, done_a;
  logic [15:0] cnt_a;
  jesd_tx_burst_gen_if #(.DATA_W(32)) if_a ();
  jesd_tx_burst_gen #(.DATA_W(32), .BURST_LEN(4), .START_VAL(16'h0000), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .resetn(rst_a), .trig_in(trig_a), .tx(if_a),
    .busy(busy_a), .done(done_a), .burst_cnt(cnt_a));

  // dut_w: wrap case, START_VAL=FFFC
  logic        rst_w, trig_w, busy_w, done_w;
  logic [15:0] cnt_w;
  jesd_tx_burst_gen_if #(.DATA_W(32)) if_w ();
  jesd_tx_burst_gen #(.DATA_W(32), .BURST_LEN(4), .START_VAL(16'hFFFC), .SYNC_STAGES(2)) dut_w (
    .clk(clk), .resetn(rst_w), .trig_in(trig_w), .tx(if_w),
    .busy(busy_w), .done(done_w), .burst_cnt(cnt_w));

  // dut_l: 256-word burst for the mid-burst reset case
  logic        rst_l, trig_l, busy_l, done_l;
  logic [15:0] cnt_l;
  jesd_tx_burst_gen_if #(.DATA_W(32)) if_l ();
  jesd_tx_burst_gen #(.DATA_W(32), .BURST_LEN(256), .START_VAL(16'h0000), .SYNC_STAGES(2)) dut_l (
    .clk(clk), .resetn(rst_l), .trig_in(trig_l), .tx(if_l),
    .busy(busy_l), .done(done_l), .burst_cnt(cnt_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rdy;
    logic [31:0] tdata;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] wexp[4];
  logic [31:0] wgot[4];

  initial begin
    int n, dones;
    logic [31:0] exp_word;

    // Row i is checked on the i-th falling edge after trig_a rises; rdy is
    // then driven for the following rising edge.
    tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 32'h0001_0000, 1'b1, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 32'h0003_0002, 1'b1, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 32'h0003_0002, 1'b1, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 32'h0003_0002, 1'b1, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 32'h0003_0002, 1'b1, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 32'h0005_0004, 1'b1, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 32'h0007_0006, 1'b1, 1'b0, 16'd0};
    tbl[10] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 16'd1};
    tbl[11] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd1};

    wexp[0] = 32'hFFFD_FFFC;
    wexp[1] = 32'hFFFF_FFFE;
    wexp[2] = 32'h0001_0000;
    wexp[3] = 32'h0003_0002;

    // Reset then idle
    rst_a = 1'b0; rst_w = 1'b0; rst_l = 1'b0;
    trig_a = 1'b0; trig_w = 1'b0; trig_l = 1'b0;
    if_a.tx_tready = 1'b1; if_w.tx_tready = 1'b1; if_l.tx_tready = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_a", {if_a.tx_tdata, 13'd0, busy_a, done_a, 1'b0}, 32'd0);
    chk("reset_a_tdata", if_a.tx_tdata, 32'd0);
    chk("reset_a_cnt", {16'd0, cnt_a}, 32'd0);
    chk("reset_w_tdata", if_w.tx_tdata, 32'd0);
    chk("reset_l_busy", {31'd0, busy_l}, 32'd0);
    rst_a = 1'b1; rst_w = 1'b1; rst_l = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_a", if_a.tx_tdata | {14'd0, busy_a, done_a, cnt_a}, 32'd0);
    end

    // Basic burst with backpressure, table driven
    trig_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_tdata", i), if_a.tx_tdata, tbl[i].tdata);
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy_a}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_done", i), {31'd0, done_a}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_cnt", i), {16'd0, cnt_a}, {16'd0, tbl[i].cnt});
      if_a.tx_tready = tbl[i].rdy;
    end

    // New burst, toggle during it, then hold trigger high
    trig_a = 1'b0;
    if_a.tx_tready = 1'b0;
    repeat (4) @(negedge clk);
    trig_a = 1'b1;
    for (int k = 0; k < 10 && !busy_a; k++) @(negedge clk);
    chk("retrig_busy", {31'd0, busy_a}, 32'd1);
    trig_a = 1'b0;
    @(negedge clk);
    trig_a = 1'b1;
    repeat (6) @(negedge clk);
    if_a.tx_tready = 1'b1;
    n = 0; dones = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (if_a.tx_tdata != 32'd0) n++;
      if (done_a) dones++;
    end
    chk("held_words", n, 32'd4);
    chk("held_dones", dones, 32'd1);
    chk("held_cnt", {16'd0, cnt_a}, 32'd2);
    chk("held_busy", {31'd0, busy_a}, 32'd0);

    // Sample wrap
    trig_w = 1'b1;
    n = 0; dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_w.tx_tdata != 32'd0 && n < 4) begin
        wgot[n] = if_w.tx_tdata;
        n++;
      end
      if (done_w) dones++;
    end
    chk("wrap_words", n, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_w%0d", i), wgot[i], wexp[i]);
    chk("wrap_dones", dones, 32'd1);
    chk("wrap_cnt", {16'd0, cnt_w}, 32'd1);

    // Reset mid-burst, then restart
    trig_l = 1'b1;
    for (int k = 0; k < 20 && if_l.tx_tdata != 32'h0003_0002; k++) @(negedge clk);
    chk("mid_word2", if_l.tx_tdata, 32'h0003_0002);
    rst_l = 1'b0;
    trig_l = 1'b0;
    @(negedge clk);
    chk("mid_rst_tdata", if_l.tx_tdata, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_l}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt_l}, 32'd0);
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idle_cnt", {16'd0, cnt_l}, 32'd0);
    trig_l = 1'b1;
    n = 0; dones = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (if_l.tx_tdata != 32'd0) begin
        exp_word = {16'(2 * n + 1), 16'(2 * n)};
        if (n == 0 || n == 255 || if_l.tx_tdata !== exp_word)
          chk($sformatf("long_w%0d", n), if_l.tx_tdata, exp_word);
        n++;
      end
      if (done_l) dones++;
    end
    chk("long_words", n, 32'd256);
    chk("long_dones", dones, 32'd1);
    chk("long_cnt", {16'd0, cnt_l}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jesd_tx_burst_gen.md
Name: jesd_tx_burst_gen

Overview:
- Transmit-side stimulus source for the JESD204 loopback test: drives the 32-bit TX data input of the JESD TX core in the block design.
- On a rising edge of the board switch trigger, emits one burst of BURST_LEN words of a deterministic 16-bit sample ramp.
- The RX side can check the burst after loopback.
- Sits beside the block-design wrapper and is clocked by the JESD core clock.

Parameters:
- DATA_W, 32, TX word width; fixed two 16-bit samples per word.
- BURST_LEN, 256, words per burst, range 1..65535.
- START_VAL, 16'h0000, first sample value of every burst.
- SYNC_STAGES, 2, synchroniser depth for trig_in, minimum 2.

Ports:
- clk  input  1  JESD core clock; single clock domain.
- resetn  input  1  synchronous active-low reset.
- trig_in  input  1  asynchronous switch level; bursts start on its rising edge.
- tx_tready  input  1  JESD TX core ready; a word is consumed on each clk edge with tx_tready=1.
- tx_tdata  output  32  TX word: [15:0] sample n, [31:16] sample n+1.
- busy  output  1  high from trigger acceptance until the burst completes.
- done  output  1  one-cycle pulse after the last word is consumed.
- burst_cnt  output  16  completed bursts; wraps 16'hFFFF to 0.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; tx_tdata=0, busy=0, done=0, burst_cnt=0; synchroniser and edge registers=0; word_cnt=0.
  - Reset takes effect mid-burst as well: the burst is abandoned and not counted.
- Trigger path:
  - trig_in passes through SYNC_STAGES flops, then into a delay flop.
  - edge = sync_out & ~delay.
  - Input rising edge to edge-high latency: SYNC_STAGES+1 cycles worst case.
- States:
  - IDLE: tx_tdata=0. On edge go to WAIT_RDY, set busy=1, sample=START_VAL, word_cnt=0.
  - WAIT_RDY: tx_tdata=0. When tx_tready=1 go to SEND. The first word is presented the following cycle.
  - SEND:
    - tx_tdata = {sample+1, sample}, 16-bit modulo arithmetic.
    - On a cycle with tx_tready=1: sample += 2, word_cnt += 1.
    - If word_cnt == BURST_LEN-1 on an accepted cycle, go to DONE.
    - tx_tready=0: tx_tdata, sample and word_cnt hold; state stays SEND, with no timeout.
  - DONE (one cycle): tx_tdata=0, busy=0, done=1, burst_cnt += 1; next state IDLE.
- Edges arriving in WAIT_RDY, SEND or DONE are ignored and not queued. trig_in held high produces no re-trigger; a new burst needs a low-then-high transition.
- Sample wrap: 16'hFFFE gives word {16'hFFFF,16'hFFFE}, followed by {16'h0001,16'h0000}.
- BURST_LEN=1: a single accepted word in SEND leads directly to DONE.
- All outputs are registered; no combinational path from tx_tready to tx_tdata.

Test Plan:
- Reset then idle: resetn low 5 cycles, tx_tready=1, trig_in=0 for 100 cycles -> tx_tdata=0, busy=0, done=0, burst_cnt=0 throughout.
- Basic burst (BURST_LEN=4, START_VAL=0, tx_tready=1):
  - Stimulus: trig_in 0->1.
  - Words: 32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006 on consecutive cycles.
  - Then done=1 for exactly one cycle and burst_cnt=1.
  - busy falls in the done cycle; edge to busy=1 is at most 3 cycles.
- Backpressure:
  - Stimulus: tx_tready low for 3 cycles after the second word.
  - tx_tdata holds 32'h00030002 for those cycles; the sequence resumes without skip or duplicate; burst still has 4 words.
- Trigger during burst / held level:
  - Stimulus: toggle trig_in 1->0->1 while busy=1, then hold trig_in=1 for 500 cycles.
  - Exactly one burst per accepted edge; burst_cnt increments once.
- Wrap: START_VAL=16'hFFFC, BURST_LEN=4 -> words 32'hFFFDFFFC, 32'hFFFFFFFE, 32'h00010000, 32'h00030002.
- Reset mid-burst: resetn low after word 2 of a 256-word burst -> next cycle tx_tdata=0, busy=0, burst_cnt unchanged at 0; a new trigger restarts from START_VAL.
